// File: rtl/spi_ram_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_pkg
// Shared definitions for the SPI burst RAM wrapper:
//   - two-bit serial command encodings
//   - protocol FSM state enumeration
//   - wrap-around address increment helper
// -----------------------------------------------------------------------------
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_WR_ADDR = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_DATA = 3'd5,
    ST_HOLD    = 3'd6
  } spi_state_t;

  // Next burst address: the last RAM word rolls over to word 0.
  function automatic int unsigned wrap_inc(input int unsigned addr,
                                           input int unsigned depth);
    if (addr == depth - 32'd1) begin
      return 32'd0;
    end else begin
      return addr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/spi_burst_ram_mem.sv
// -----------------------------------------------------------------------------
// spi_burst_ram_mem
// Single-port synchronous RAM, DATA_W x MEM_DEPTH, registered read data.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable: mem[addr] <= wdata
//   re     in   read enable:  rdata <= mem[addr] (one-cycle latency)
//   addr   in   ADDR_W word address (accesses outside MEM_DEPTH are ignored)
//   wdata  in   DATA_W write data
//   rdata  out  DATA_W registered read data, held until the next read
// -----------------------------------------------------------------------------
module spi_burst_ram_mem #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [MEM_DEPTH];
  logic              in_range_s;

  assign in_range_s = (32'(addr) < 32'(MEM_DEPTH));

  // RAM array write and registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we && in_range_s) begin
      mem_r[addr] <= wdata;
    end
    if (re && in_range_s) begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/spi_burst_ram_wrapper.sv
// -----------------------------------------------------------------------------
// spi_burst_ram_wrapper
// SPI slave front-end to a parametrised RAM with auto-increment bursts.
// Frame: cycle 0 turnaround, cycles 1-2 command bits, payload from cycle 3.
// Ports:
//   clk    in   system clock (SCK already synchronous to it)
//   rst_n  in   asynchronous active-low reset
//   SS_n   in   slave select, active low, frame delimiter
//   MOSI   in   serial data in, MSB first
//   MISO   out  serial data out, MSB first, registered; 0 unless streaming
// -----------------------------------------------------------------------------
module spi_burst_ram_wrapper
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int SHIFT_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int CNT_W   = $clog2(SHIFT_W + 1);
  localparam int IDX_W   = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);

  spi_state_t        state_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [SHIFT_W-2:0] shift_r;   // previous bits; the newest bit is MOSI itself
  logic [ADDR_W-1:0] wr_addr_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              cmd_hi_r;
  logic              rd_started_r;
  logic              miso_r;

  logic              data_last_s;
  logic [ADDR_W-1:0] addr_word_s;
  logic [ADDR_W-1:0] wr_addr_next_s;
  logic [ADDR_W-1:0] rd_addr_next_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic              mem_we_s;
  logic              mem_re_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [DATA_W-1:0] mem_rdata_s;

  assign data_last_s    = (bit_cnt_r == DATA_LAST);
  assign addr_word_s    = {shift_r[ADDR_W-2:0], MOSI};
  assign mem_wdata_s    = {shift_r[DATA_W-2:0], MOSI};
  assign wr_addr_next_s = ADDR_W'(wrap_inc(32'(wr_addr_r), 32'(MEM_DEPTH)));
  assign rd_addr_next_s = ADDR_W'(wrap_inc(32'(rd_addr_r), 32'(MEM_DEPTH)));
  assign rd_idx_s       = IDX_W'(DATA_W - 1) - IDX_W'(bit_cnt_r);
  assign MISO           = miso_r;

  // RAM strobes: a completed write word commits even if SS_n rises on that
  // edge; a read is issued at cycle 3 and again on each word's last bit.
  always_comb begin
    mem_we_s   = 1'b0;
    mem_re_s   = 1'b0;
    mem_addr_s = wr_addr_r;
    if (state_r == ST_WR_DATA && data_last_s) begin
      mem_we_s = 1'b1;
    end else if (state_r == ST_RD_DATA && !SS_n && (!rd_started_r || data_last_s)) begin
      mem_re_s   = 1'b1;
      mem_addr_s = rd_addr_r;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Protocol FSM with shifter, bit counter, address registers and MISO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      wr_addr_r    <= '0;
      rd_addr_r    <= '0;
      cmd_hi_r     <= 1'b0;
      rd_started_r <= 1'b0;
      miso_r       <= 1'b0;
    end else if (SS_n) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= '0;
      rd_started_r <= 1'b0;
      miso_r       <= 1'b0;
      if (state_r == ST_WR_DATA && data_last_s) begin
        wr_addr_r <= wr_addr_next_s;
      end
    end else begin
      shift_r <= {shift_r[SHIFT_W-3:0], MOSI};
      miso_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          state_r   <= ST_CMD;
          bit_cnt_r <= '0;
        end
        ST_CMD: begin
          if (bit_cnt_r == '0) begin
            cmd_hi_r  <= MOSI;
            bit_cnt_r <= CNT_W'(1);
          end else begin
            bit_cnt_r    <= '0;
            rd_started_r <= 1'b0;
            case ({cmd_hi_r, MOSI})
              CMD_WR_ADDR: state_r <= ST_WR_ADDR;
              CMD_WR_DATA: state_r <= ST_WR_DATA;
              CMD_RD_ADDR: state_r <= ST_RD_ADDR;
              CMD_RD_DATA: state_r <= ST_RD_DATA;
              default:     state_r <= ST_HOLD;
            endcase
          end
        end
        ST_WR_ADDR: begin
          if (bit_cnt_r == ADDR_LAST) begin
            wr_addr_r <= addr_word_s;
            bit_cnt_r <= '0;
            state_r   <= ST_HOLD;
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          end
        end
        ST_RD_ADDR: begin
          if (bit_cnt_r == ADDR_LAST) begin
            rd_addr_r <= addr_word_s;
            bit_cnt_r <= '0;
            state_r   <= ST_HOLD;
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          end
        end
        ST_WR_DATA: begin
          if (data_last_s) begin
            wr_addr_r <= wr_addr_next_s;
            bit_cnt_r <= '0;
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          end
        end
        ST_RD_DATA: begin
          if (!rd_started_r) begin
            // Cycle 3: first read issued, data is on mem_rdata_s next edge.
            rd_started_r <= 1'b1;
            rd_addr_r    <= rd_addr_next_s;
            bit_cnt_r    <= '0;
          end else begin
            miso_r <= mem_rdata_s[rd_idx_s];
            if (data_last_s) begin
              // Prefetch issued this edge keeps words back to back.
              rd_addr_r <= rd_addr_next_s;
              bit_cnt_r <= '0;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          bit_cnt_r <= '0;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  spi_burst_ram_mem #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we_s),
    .re   (mem_re_s),
    .addr (mem_addr_s),
    .wdata(mem_wdata_s),
    .rdata(mem_rdata_s)
  );

endmodule

// File: tb/tb_spi_burst_ram_wrapper.sv
// -----------------------------------------------------------------------------
// tb_spi_burst_ram_wrapper
// Directed and randomized frames against two wrapper instances:
//   inst 0: defaults (8-bit data, 8-bit address, 256 words)
//   inst 1: 16-bit data, 4-bit address, 10 words
// A behavioural model (word array + two burst pointers) predicts MISO.
// -----------------------------------------------------------------------------
module tb_spi_burst_ram_wrapper;
  import spi_ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic ss_a, mosi_a, miso_a;
  logic ss_b, mosi_b, miso_b;

  int checks = 0;
  int errors = 0;

  logic [15:0] mdl [2][256];
  int          wa [2];
  int          ra [2];

  always #5 clk = ~clk;

  spi_burst_ram_wrapper dut_a (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_a), .MOSI(mosi_a), .MISO(miso_a)
  );

  spi_burst_ram_wrapper #(.DATA_W(16), .ADDR_W(4), .MEM_DEPTH(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_b), .MOSI(mosi_b), .MISO(miso_b)
  );

  function automatic int dw(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic int aw(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic int depth(input int i);
    return (i == 0) ? 256 : 10;
  endfunction

  function automatic int next_addr(input int i, input int a);
    return (a + 1) % depth(i);
  endfunction

  function automatic logic miso_of(input int i);
    return (i == 0) ? miso_a : miso_b;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One serial edge: drive at the falling edge, settle 1 after the rising edge.
  task automatic drive(input int i, input logic ss, input logic mosi);
    @(negedge clk);
    if (i == 0) begin
      ss_a = ss; mosi_a = mosi;
    end else begin
      ss_b = ss; mosi_b = mosi;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start(input int i, input logic [1:0] cmd);
    drive(i, 1'b0, 1'($urandom));
    chk("miso_cyc0", miso_of(i), 1'b0);
    drive(i, 1'b0, cmd[1]);
    chk("miso_cyc1", miso_of(i), 1'b0);
    drive(i, 1'b0, cmd[0]);
    chk("miso_cyc2", miso_of(i), 1'b0);
  endtask

  task automatic frame_end(input int i);
    drive(i, 1'b1, 1'($urandom));
    chk("miso_ss_high", miso_of(i), 1'b0);
  endtask

  task automatic addr_frame(input int i, input bit rd, input int a);
    logic [15:0] v;
    v = 16'(a);
    frame_start(i, rd ? CMD_RD_ADDR : CMD_WR_ADDR);
    for (int b = aw(i) - 1; b >= 0; b--) begin
      drive(i, 1'b0, v[b]);
      chk("miso_addr", miso_of(i), 1'b0);
    end
    drive(i, 1'b0, 1'($urandom));
    chk("miso_hold", miso_of(i), 1'b0);
    frame_end(i);
    if (rd) ra[i] = a; else wa[i] = a;
  endtask

  // simul=1 raises SS_n on the edge that samples the final data bit.
  task automatic wr_frame(input int i, input logic [15:0] words[$], input bit simul);
    logic last;
    frame_start(i, CMD_WR_DATA);
    for (int w = 0; w < words.size(); w++) begin
      for (int b = dw(i) - 1; b >= 0; b--) begin
        last = simul && (w == words.size() - 1) && (b == 0);
        drive(i, last, words[w][b]);
        chk("miso_wr", miso_of(i), 1'b0);
      end
      mdl[i][wa[i]] = words[w];
      wa[i] = next_addr(i, wa[i]);
    end
    if (!simul) frame_end(i);
  endtask

  task automatic rd_frame(input int i, input int n);
    int p;
    logic [15:0] word;
    frame_start(i, CMD_RD_DATA);
    drive(i, 1'b0, 1'($urandom));
    chk("miso_cyc3", miso_of(i), 1'b0);
    p = ra[i];
    for (int w = 0; w < n; w++) begin
      word = mdl[i][p];
      for (int b = dw(i) - 1; b >= 0; b--) begin
        drive(i, 1'b0, 1'($urandom));
        chk("miso_rd", miso_of(i), word[b]);
      end
      p = next_addr(i, p);
    end
    // A read of the following word was already issued with the last bit.
    ra[i] = next_addr(i, p);
    frame_end(i);
  endtask

  task automatic partial_frame(input int i, input logic [1:0] cmd, input int nbits);
    frame_start(i, cmd);
    for (int b = 0; b < nbits; b++) begin
      drive(i, 1'b0, 1'($urandom));
      chk("miso_partial", miso_of(i), 1'b0);
    end
    frame_end(i);
  endtask

  initial begin
    logic [15:0] q[$];
    int i, a, n;
    rst_n = 1'b0;
    ss_a = 1'b1; mosi_a = 1'b0;
    ss_b = 1'b1; mosi_b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wa[k] = 0; ra[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_miso_a", miso_a, 1'b0);
    chk("reset_miso_b", miso_b, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic burst write and contiguous burst read.
    addr_frame(0, 1'b0, 8'h05);
    q = {16'h00A1, 16'h00B2, 16'h00C3};
    wr_frame(0, q, 1'b0);
    addr_frame(0, 1'b1, 8'h05);
    rd_frame(0, 3);

    // Address wrap at the top of RAM; third word proves wr_addr is now 1.
    addr_frame(0, 1'b0, 8'hFF);
    q = {16'h0011, 16'h0022};
    wr_frame(0, q, 1'b0);
    q = {16'h0033};
    wr_frame(0, q, 1'b0);
    addr_frame(0, 1'b1, 8'hFF);
    rd_frame(0, 3);

    // Aborted data word and aborted address leave RAM and pointers alone.
    addr_frame(0, 1'b0, 8'h10);
    q = {16'h003C};
    wr_frame(0, q, 1'b0);
    addr_frame(0, 1'b0, 8'h10);
    partial_frame(0, CMD_WR_DATA, 5);
    addr_frame(0, 1'b1, 8'h10);
    rd_frame(0, 1);
    q = {16'h005A};
    wr_frame(0, q, 1'b0);
    partial_frame(0, CMD_WR_ADDR, 5);
    q = {16'h006B};
    wr_frame(0, q, 1'b0);
    addr_frame(0, 1'b1, 8'h10);
    rd_frame(0, 2);

    // Last data bit sampled on the same edge SS_n rises: word still lands.
    addr_frame(0, 1'b0, 8'h40);
    q = {16'h009C, 16'h00E7};
    wr_frame(0, q, 1'b1);
    addr_frame(0, 1'b1, 8'h40);
    rd_frame(0, 2);

    // Asynchronous reset in the middle of a streamed word.
    frame_start(0, CMD_RD_DATA);
    drive(0, 1'b0, 1'b0);
    for (int b = 7; b >= 5; b--) begin
      drive(0, 1'b0, 1'b0);
      chk("miso_pre_rst", miso_a, mdl[0][ra[0]][b]);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("miso_async_rst", miso_a, 1'b0);
    ss_a = 1'b1;
    @(posedge clk);
    #1;
    chk("miso_in_rst", miso_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wa[k] = 0; ra[k] = 0;
    end
    rd_frame(0, 1);
    q = {16'h0077};
    wr_frame(0, q, 1'b0);
    addr_frame(0, 1'b1, 8'h00);
    rd_frame(0, 2);
    addr_frame(0, 1'b1, 8'h05);
    rd_frame(0, 1);

    // Wide-data, shallow instance with wrap at word 9.
    addr_frame(1, 1'b0, 9);
    q = {16'hBEEF, 16'h1234};
    wr_frame(1, q, 1'b0);
    addr_frame(1, 1'b1, 9);
    rd_frame(1, 2);

    // Back-to-back frames separated by a single SS_n-high cycle.
    addr_frame(0, 1'b1, 8'h41);
    rd_frame(0, 1);

    // Randomized bursts on both instances.
    for (int it = 0; it < 10; it++) begin
      i = it % 2;
      a = $urandom_range(0, depth(i) - 1);
      n = $urandom_range(1, 4);
      q = {};
      for (int k = 0; k < n; k++) begin
        q.push_back((i == 0) ? {8'h00, 8'($urandom)} : 16'($urandom));
      end
      addr_frame(i, 1'b0, a);
      wr_frame(i, q, 1'b0);
      addr_frame(i, 1'b1, a);
      rd_frame(i, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_burst_ram_wrapper.md
Name: spi_burst_ram_wrapper

Overview:
- Parametrised SPI-slave-plus-RAM block; successor to the fixed 8-bit, 256-deep SPI wrapper.
- Same four-command serial protocol: write address, write data, read address, read data.
- Generalised in data width, address width and depth.
- Adds auto-increment burst write/read while SS_n stays low.
- Sits behind an external SPI master clocked on clk (SCK already synchronous to clk).

Parameters:
DATA_W, 8, RAM word width and serial data payload length in bits
ADDR_W, 8, address register width and serial address payload length in bits
MEM_DEPTH, 256, number of RAM words; must be <= 2**ADDR_W

Ports:
clk  in  1  system clock; all sampling on rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
SS_n  in  1  slave select, active low; frame delimiter
MOSI  in  1  serial data in, MSB first
MISO  out  1  serial data out, MSB first

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; MISO=0; wr_addr=0; rd_addr=0; shift/bit counters=0.
  - RAM contents are not cleared.
- States: IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, HOLD.
- Frame cycle numbering: cycle 0 is the first edge with SS_n sampled 0.
- Cycle 0: IDLE->CMD; MOSI ignored (turnaround).
- Cycles 1-2: command bits c1,c0. Encoding: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- Payload starts at cycle 3, MSB first.
- WR_ADDR / RD_ADDR:
  - ADDR_W payload bits.
  - On the edge sampling the last bit, wr_addr (resp. rd_addr) <= payload.
  - Then HOLD; MOSI ignored until SS_n=1.
- WR_DATA (burst):
  - Every DATA_W bits form a word.
  - On the last-bit edge: RAM[wr_addr] <= word; wr_addr <= (wr_addr==MEM_DEPTH-1) ? 0 : wr_addr+1.
  - Next word's MSB is sampled on the very next edge (no gap).
- RD_DATA (burst):
  - Cycle 3: synchronous RAM read of rd_addr issued.
  - MISO carries bit DATA_W-1 of that word from the edge of cycle 4 through cycle 4+DATA_W-1, one bit per edge.
  - rd_addr wraps/increments exactly as wr_addr, when each read is issued.
  - The next word's read is issued on the edge driving the current word's last bit, so words stream contiguously.
  - MOSI ignored in RD_DATA.
- MISO = 0 in every state other than RD_DATA shifting.
- SS_n sampled 1 in any state: next state IDLE, MISO=0 on that edge.
  - Partial address or data word discarded; no RAM write; address registers unchanged.
- SS_n high for a single cycle between frames is sufficient; the next low starts a new cycle 0.
- Simultaneous last-bit write and SS_n rise on the same edge: the word is complete and is written.
- No read-during-write hazard: a read and a write are never in the same frame.

Decomposition:
- Package spi_ram_pkg holds:
  - command encoding constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - state enumeration;
  - a function for address-wrap increment.
- One natural sub-module: spi_burst_ram_mem.
  - Single-port synchronous RAM, DATA_W x MEM_DEPTH, registered read, write-enable.
  - The protocol FSM, shifters and counters stay in the top.

Test Plan:
1. Defaults. WR_ADDR 0x05, WR_DATA burst 0xA1,0xB2,0xC3; RD_ADDR 0x05, RD_DATA 24 bits -> MISO streams A1,B2,C3 contiguously from cycle 4; MISO=0 before and after.
2. Wrap. WR_ADDR 0xFF, burst 0x11,0x22; read from 0xFF for 2 words -> 0x11 then 0x22 (RAM[0]); wr_addr ends at 0x01.
3. Abort. WR_ADDR 0x10, then WR_DATA with SS_n raised after 5 payload bits -> RAM[0x10] unchanged. A following WR_DATA 0x5A lands at 0x10.
4. Reset mid-read. rst_n=0 during RD_DATA bit 3 -> MISO=0 immediately (async), state IDLE, addresses 0, RAM retained. Re-read after release returns prior data.
5. Params DATA_W=16, ADDR_W=4, MEM_DEPTH=10. WR_ADDR 9, burst 0xBEEF,0x1234 -> RAM[9]=0xBEEF, RAM[0]=0x1234; read-back matches.
6. Back-to-back. Frames separated by one SS_n-high cycle; RD_ADDR then RD_DATA -> correct first word; CMD sampled at cycles 1-2 of each frame.
